hazard_scoreboard: RTL

- Tracks in-flight register writes between the decode stage and write-back. Raises a stall ("hazard") when the instruction in decode reads a register that is still pending.
- Owns the branch-flush sequencing for the front end. Sequences flush after a taken branch.
- Sits beside the decode stage. Its hazard output drives the decode-stage control-zeroing mux and the PC/IF-ID register freeze.

---
 rtl/hazard_scoreboard.sv | 137 +++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard scoreboard with branch-flush sequencing and a saturating stall counter.
// Optional macro HAZARD_FORWARDING_EN: only load-use on the EX entry stalls.
module hazard_scoreboard #(
  parameter int DEPTH        = 2,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic [3:0]       src1,
  input  logic [3:0]       src2,
  input  logic             two_src,
  input  logic             src1_used,
  input  logic             id_wb_en,
  input  logic             id_mem_read,
  input  logic [3:0]       id_dest,
  input  logic             branch_taken,
  output logic             hazard,
  output logic             flush,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] dest;
    logic       is_load;
  } entry_t;

  state_e           state_q;
  logic [1:0]       fcnt_q;
  entry_t           entry_q [DEPTH];
  entry_t           entry_d [DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             match_s;
  logic             unused_last_s;

  // The oldest entry only ever drops out; it is kept for structural clarity.
  assign unused_last_s = ^entry_q[DEPTH-1];

  always_comb begin
    match_s = 1'b0;
`ifdef HAZARD_FORWARDING_EN
    match_s = entry_q[0].valid & entry_q[0].is_load &
              ((src1_used & (entry_q[0].dest == src1)) |
               (two_src   & (entry_q[0].dest == src2)));
`else
    for (int k = 0; k < DEPTH; k++) begin
      match_s = match_s | (entry_q[k].valid &
                ((src1_used & (entry_q[k].dest == src1)) |
                 (two_src   & (entry_q[k].dest == src2))));
    end
`endif
  end

  // A flush discards the decode instruction, so it masks any stall.
  assign flush       = (state_q == FLUSH) | branch_taken;
  assign hazard      = match_s & ~flush;
  assign stall_count = cnt_q;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      entry_d[k] = entry_q[k];
    end
    cnt_d = cnt_q;
    if (!freeze) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        entry_d[k] = entry_q[k-1];
      end
      if (id_wb_en && !hazard && !flush) begin
        entry_d[0] = '{valid: 1'b1, dest: id_dest, is_load: id_mem_read};
      end else begin
        entry_d[0] = '{valid: 1'b0, dest: 4'd0, is_load: 1'b0};
      end
      if (hazard && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        entry_q[k] <= '{valid: 1'b0, dest: 4'd0, is_load: 1'b0};
      end
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        entry_q[k] <= entry_d[k];
      end
      cnt_q <= cnt_d;
    end
  end

  // Flush sequencer: a branch seen in FLUSH is wrong-path and ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fcnt_q  <= 2'd0;
    end else if (freeze) begin
      state_q <= state_q;
      fcnt_q  <= fcnt_q;
    end else begin
      case (state_q)
        IDLE: begin
          if (branch_taken && (FLUSH_CYCLES > 1)) begin
            state_q <= FLUSH;
            fcnt_q  <= 2'(FLUSH_CYCLES - 1);
          end else begin
            state_q <= IDLE;
            fcnt_q  <= 2'd0;
          end
        end
        FLUSH: begin
          fcnt_q <= fcnt_q - 2'd1;
          if (fcnt_q <= 2'd1) begin
            state_q <= IDLE;
          end else begin
            state_q <= FLUSH;
          end
        end
        default: begin
          state_q <= IDLE;
          fcnt_q  <= 2'd0;
        end
      endcase
    end
  end

endmodule
